// File: rtl/rca_chunked_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit ripple slice per clock, with the
// inter-slice carry held in a register, behind valid/ready handshakes.
module rca_chunked_adder #(
    parameter  int WIDTH  = 16,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK:0]   w_slice;
    logic             w_last;
    logic             w_msb_cin;

    // Constant-index mux keeps the slice select free of variable part-selects
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (r_idx == CW'(k)) begin
                w_a_sl = r_a[k*CHUNK +: CHUNK];
                w_b_sl = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_slice   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
    assign w_last    = (r_idx == CW'(NCHUNK - 1));
    // Carry into the MSB recovered from the MSB's own sum bit
    assign w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (r_idx == CW'(k)) begin
                            r_sum[k*CHUNK +: CHUNK] <= w_slice[CHUNK-1:0];
                        end
                    end
                    r_carry <= w_slice[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_slice[CHUNK];
                        r_ovf   <= w_msb_cin ^ w_slice[CHUNK];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_chunked_adder.sv
// Scoreboard bench for rca_chunked_adder (WIDTH=16, CHUNK=4).
module tb_rca_chunked_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    rca_chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                   input logic tc, input logic ts);
        exp_t         e;
        logic [WIDTH:0] full;
        if (ts) full = {1'b0, ta} + {1'b0, ~tb} + 1;
        else    full = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
        e.s = full[WIDTH-1:0];
        e.c = full[WIDTH];
        if (ts) e.o = (ta[WIDTH-1] != tb[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
        else    e.o = (ta[WIDTH-1] == tb[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
        return e;
    endfunction

    // Accept one operation, scramble inputs during CALC, check latency,
    // result, optional backpressure hold, and return to IDLE.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input logic ts, input int hold, input string name);
        exp_t e;
        int   lat;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        q.push_back(model(ta, tb, tc, ts));
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s in_ready_calc: got %b want 0", name, in_ready);
                end
                if (lat == 1) begin
                    checks++;
                    if (sum !== '0) begin
                        failures++;
                        $display("FAIL %s sum_cleared: got %h want 0000", name, sum);
                    end
                end
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'($urandom);
            end
        end while (!out_valid && lat < 20);
        in_valid = 1'b0;
        checks++;
        if (lat !== NCHUNK + 1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s latency: got %0d negedges (out_valid=%b) want %0d", name, lat, out_valid, NCHUNK + 1);
        end
        if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
            return;
        end
        e = q.pop_front();
        checks++;
        if (sum !== e.s || cout !== e.c || ovf !== e.o || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b in_ready=%b want sum=%h cout=%b ovf=%b in_ready=0",
                     name, sum, cout, ovf, in_ready, e.s, e.c, e.o);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            checks++;
            if (out_valid !== 1'b1 || sum !== e.s || cout !== e.c || ovf !== e.o || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s hold%0d: got v=%b sum=%h cout=%b ovf=%b rdy=%b want v=1 sum=%h cout=%b ovf=%b rdy=0",
                         name, i, out_valid, sum, cout, ovf, in_ready, e.s, e.c, e.o);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s release: got in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset: got rdy=%b v=%b sum=%h cout=%b ovf=%b want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "basic_add");
    endtask

    task automatic test_carry_chain();
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, "carry_chain");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_ovf");
    endtask

    task automatic test_subtract();
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
    endtask

    task automatic test_backpressure();
        run_op(16'h1357, 16'h2468, 1'b1, 1'b0, 6, "backpressure");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), i % 3, "random");
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got rdy=%b v=%b sum=%h cout=%b ovf=%b want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_stale%0d: got v=%b rdy=%b want 0 1", i, out_valid, in_ready);
            end
        end
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_subtract();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_chunked_adder.md
Name: rca_chunked_adder

Overview:
- Parametrised, multi-cycle successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands one CHUNK-bit ripple slice per clock, carrying between slices in a register.
- Wrapped in valid/ready handshakes so it can sit between pipeline stages without a wide single-cycle carry chain.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock (ripple-carry slice width).
- NCHUNK, WIDTH/CHUNK, derived slice count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on a, b, cin, sub.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (any time, including mid-operation): state=IDLE, chunk counter=0, operand/carry registers=0.
  - Outputs at reset: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Any in-flight operation is discarded; no output is produced for it.
- State machine (IDLE, CALC, DONE):
  - IDLE: in_ready=1, out_valid=0.
    - On edge with in_valid=1: capture a and b; for sub=1 capture ~b.
    - Initial carry = sub ? 1 : cin. Clear chunk index to 0. Go to CALC.
  - CALC: in_ready=0, out_valid=0.
    - Each edge: slice k = captured_a[k*CHUNK +: CHUNK] + captured_b[same] + carry.
    - Write the low CHUNK bits into sum[k*CHUNK +: CHUNK]; the slice carry-out becomes the next carry; k increments.
    - On the edge processing k=NCHUNK-1:
      - cout = final carry.
      - ovf = carry into MSB XOR carry out of MSB.
      - Go to DONE.
  - DONE: out_valid=1, in_ready=0. sum, cout and ovf are held stable.
    - On edge with out_ready=1: go to IDLE.
    - While out_ready=0: remain in DONE indefinitely with outputs unchanged.
- Latency: operation accepted at edge T; out_valid rises after edge T+NCHUNK.
- Throughput: one operation per NCHUNK+2 cycles with out_ready held high. No back-to-back accept in DONE; in_ready is a pure function of state.
- Output stability:
  - Changes on a, b, cin, sub after acceptance have no effect.
  - in_valid while in CALC or DONE is ignored (not captured).
  - sum bits for slices not yet computed hold 0 from the capture edge until written (sum is cleared on acceptance).
- Arithmetic:
  - Result modulo 2^WIDTH.
  - For sub=1, cin is ignored and the result equals a-b modulo 2^WIDTH.
  - CHUNK==WIDTH is legal: NCHUNK=1, single CALC cycle.
- Simultaneous events:
  - Reset assertion overrides every handshake.
  - out_ready asserted while not in DONE has no effect.

Test Plan (WIDTH=16, CHUNK=4):
- Reset: pulse rst_n low mid-cycle, no clock edge -> in_ready=1, out_valid=0, sum=0x0000, cout=0, ovf=0 immediately.
- Basic add: a=0x0001, b=0x0001, cin=0, sub=0, accept at edge T -> out_valid=1 after edge T+4, sum=0x0002, cout=0, ovf=0; in_ready=0 from T through the DONE handshake.
- Full carry chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 slices). Then a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure and operand isolation:
  - Hold out_ready=0 for 6 cycles in DONE -> out_valid, sum, cout, ovf stable; in_ready=0.
  - Toggle a and b randomly during CALC -> result unchanged.
  - Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-operation: accept 0x1234+0x1111, assert rst_n=0 after 2 CALC edges -> outputs return to reset values; after release, a new 0x0003+0x0004 yields sum=0x0007 with no stale result.
